// File: rtl/gate_truth_checker.sv
// Clocked stimulus/check stage for a 2-input gate: walks {a,b} through 00..11, samples c after
// a programmable settle time and records per-vector mismatches against the selected truth table.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] mismatch_vec,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mis_q, mis_d;
  logic       pass_q, pass_d;
  logic       expected;
  logic       mismatch;
  logic       va, vb;

  assign va = vec_q[1];
  assign vb = vec_q[0];

  always_comb begin
    expected = 1'b0;
    unique case (sel_q)
      3'd0: expected = va & vb;
      3'd1: expected = va | vb;
      3'd2: expected = ~(va & vb);
      3'd3: expected = ~(va | vb);
      3'd4: expected = va ^ vb;
      3'd5: expected = ~(va ^ vb);
      3'd6: expected = va;
      3'd7: expected = ~va;
      default: expected = 1'b0;
    endcase
  end

  // Written so an unknown c (x/z) falls through to a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (c == expected) mismatch = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    mis_d   = mis_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_d   = gate_sel;
          err_d   = 3'd0;
          mis_d   = 4'd0;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          pass_d  = 1'b0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == SettleLast) state_d = StSample;
        else                     cnt_d = cnt_q + 4'd1;
      end
      StSample: begin
        if (mismatch) begin
          mis_d[vec_q] = 1'b1;
          err_d        = err_q + 3'd1;
        end
        if (vec_q == 2'd3) begin
          state_d = StDone;
          pass_d  = (err_d == 3'd0);
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = StDrive;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 3'd0;
      cnt_q   <= 4'd0;
      vec_q   <= 2'd0;
      err_q   <= 3'd0;
      mis_q   <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
    end
  end

  // Outputs decode only flopped state, so c never reaches an output combinationally.
  always_comb begin
    a            = 1'b0;
    b            = 1'b0;
    if (state_q == StDrive || state_q == StSample) begin
      a = va;
      b = vb;
    end
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    pass         = pass_q;
    err_count    = err_q;
    mismatch_vec = mis_q;
    vec_idx      = vec_q;
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Self-checking bench for gate_truth_checker: a behavioural gate drives c, and expected results
// come from truth-table arithmetic (bitwise XOR of expected and actual gate tables).
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [2:0] gsel0, gsel1;
  logic       a0, b0, c0, a1, b1, c1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mis0, mis1;
  logic [1:0] vidx0, vidx1;

  logic [2:0] cg0, cg1;
  int         xvec0 = -1;
  int         cur   = 0;
  int         checks = 0;
  int         errors = 0;

  logic       oa, ob, obusy, odone, opass;
  logic [2:0] oerr;
  logic [3:0] omis;
  logic [1:0] ovidx;
  logic [3:0] tt0, tt1;

  always #5 clk = ~clk;

  gate_truth_checker #(.SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_sel(gsel0), .a(a0), .b(b0), .c(c0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .mismatch_vec(mis0),
    .vec_idx(vidx0)
  );

  gate_truth_checker #(.SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_sel(gsel1), .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .mismatch_vec(mis1),
    .vec_idx(vidx1)
  );

  // Truth table of each gate type, bit i = output for {a,b} = i.
  function automatic logic [3:0] truth(input logic [2:0] g);
    case (g)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  always_comb begin
    tt0 = truth(cg0);
    c0  = tt0[{a0, b0}];
    if (xvec0 == int'({a0, b0})) c0 = 1'bx;
    tt1 = truth(cg1);
    c1  = tt1[{a1, b1}];
  end

  always_comb begin
    if (cur == 0) begin
      oa = a0; ob = b0; obusy = busy0; odone = done0; opass = pass0;
      oerr = err0; omis = mis0; ovidx = vidx0;
    end else begin
      oa = a1; ob = b1; obusy = busy1; odone = done1; opass = pass1;
      oerr = err1; omis = mis1; ovidx = vidx1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " a"}, 32'(oa), 0);
    check({tag, " b"}, 32'(ob), 0);
    check({tag, " busy"}, 32'(obusy), 0);
    check({tag, " done"}, 32'(odone), 0);
    check({tag, " pass"}, 32'(opass), 0);
    check({tag, " err_count"}, 32'(oerr), 0);
    check({tag, " mismatch_vec"}, 32'(omis), 0);
    check({tag, " vec_idx"}, 32'(ovidx), 0);
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_sel(input int which, input logic [2:0] v);
    if (which == 0) gsel0 = v; else gsel1 = v;
  endtask

  // Launch one run on the chosen DUT and check schedule, stimulus and final verdict.
  task automatic run(input int which, input logic [2:0] sel, input logic [2:0] cg, input int xv,
                     input bit disturb, input string tag);
    int         s, exp_done, done_at, vec;
    logic [3:0] exp_mis;
    bit         seq_ok;
    s        = (which == 0) ? 1 : 3;
    exp_done = 4 * (s + 1) + 1;
    exp_mis  = truth(sel) ^ truth(cg);
    if (xv >= 0) exp_mis[xv[1:0]] = 1'b1;
    cur = which;
    if (which == 0) begin cg0 = cg; xvec0 = xv; end
    else            cg1 = cg;
    set_sel(which, sel);
    set_start(which, 1'b1);
    done_at = -1;
    seq_ok  = 1'b1;
    for (int k = 1; k <= exp_done + 4; k++) begin
      @(negedge clk);
      if (disturb) begin
        set_start(which, (k == exp_done) ? 1'b1 : 1'($urandom_range(0, 1)));
        set_sel(which, 3'($urandom));
      end else begin
        set_start(which, 1'b0);
      end
      if (odone === 1'b1) begin
        done_at = k;
        break;
      end
      vec = (k - 1) / (s + 1);
      if (obusy !== 1'b1 || oa !== vec[1] || ob !== vec[0] || ovidx !== 2'(vec)) seq_ok = 1'b0;
    end
    check({tag, " done_cycle"}, 32'(done_at), 32'(exp_done));
    check({tag, " stimulus_seq"}, 32'(seq_ok), 1);
    check({tag, " busy@done"}, 32'(obusy), 1);
    check({tag, " ab@done"}, 32'({oa, ob}), 0);
    check({tag, " pass"}, 32'(opass), 32'(exp_mis == 4'd0));
    check({tag, " err_count"}, 32'(oerr), 32'($countones(exp_mis)));
    check({tag, " mismatch_vec"}, 32'(omis), 32'(exp_mis));
    @(negedge clk);
    set_start(which, 1'b0);
    xvec0 = -1;
    check({tag, " idle_busy"}, 32'(obusy), 0);
    check({tag, " idle_done"}, 32'(odone), 0);
    check({tag, " held_result"}, 32'({opass, oerr, omis}),
          32'({exp_mis == 4'd0, 3'($countones(exp_mis)), exp_mis}));
  endtask

  initial begin
    logic [2:0] rs, rc;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; gsel0 = 3'd0; gsel1 = 3'd0;
    cg0 = 3'd0; cg1 = 3'd0;
    repeat (2) @(negedge clk);
    cur = 0; check_reset("reset0");
    cur = 1; check_reset("reset1");
    rst = 1'b0;
    @(negedge clk);

    run(0, 3'd1, 3'd1, -1, 1'b0, "or_ok");
    run(0, 3'd1, 3'd0, -1, 1'b0, "or_vs_and");
    run(0, 3'd4, 3'd4, 2, 1'b0, "xor_x_vec2");

    // Reset during vector-1 sample (cycle 4) after vector 0 has already mismatched.
    cur = 0; gsel0 = 3'd2; cg0 = 3'd0; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun err_count", 32'(oerr), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midrun_reset");
    run(0, 3'd3, 3'd3, -1, 1'b0, "post_reset");

    run(0, 3'd5, 3'd5, -1, 1'b1, "disturb_ok");
    run(0, 3'd0, 3'd6, -1, 1'b1, "disturb_bad");

    for (int i = 0; i < 6; i++) begin
      rs = 3'($urandom);
      rc = ($urandom_range(0, 1) == 1) ? rs : 3'($urandom);
      run(0, rs, rc, -1, 1'b0, "random");
    end

    run(1, 3'd7, 3'd7, -1, 1'b0, "settle3_first");
    run(1, 3'd7, 3'd7, -1, 1'b0, "settle3_back2back");
    run(1, 3'd6, 3'd3, -1, 1'b0, "settle3_bad");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Sequential stimulus-and-check stage that sits directly upstream of a 2-input logic gate: drives a/b through all four input combinations and consumes the gate's output c. Compares c against the expected truth table for a selected gate type and reports per-vector mismatches, an error count and pass/fail. This is the clocked, self-checking replacement for hand-written gate benches.

Parameters:
SETTLE_CYCLES, 1, cycles a/b are held before c is sampled for each vector (legal range 1..15)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin a check run; accepted only in IDLE
gate_sel  input  3  gate type under test; latched on accepted start
a  output  1  stimulus input a to the gate under test
b  output  1  stimulus input b to the gate under test
c  input  1  output of the gate under test
busy  output  1  high from the cycle after an accepted start until DONE, inclusive
done  output  1  one-cycle pulse at end of run
pass  output  1  1 when the last run had zero mismatches; held until the next accepted start
err_count  output  3  number of mismatched vectors in the current/last run (0..4)
mismatch_vec  output  4  bit i set if vector i mismatched
vec_idx  output  2  index of the vector currently driven

Behaviour:
- Reset (rst=1 at posedge, any state, including mid-run): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, mismatch_vec=0, vec_idx=0, settle counter=0.
- gate_sel encoding (expected c): 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF_A (c=a), 7 NOT_A (c=~a).
- Vector order: vec_idx 0..3 -> {a,b} = 00, 01, 10, 11 (a=vec_idx[1], b=vec_idx[0]).
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: a=b=0, busy=0. start=1 -> latch gate_sel, clear err_count and mismatch_vec, vec_idx=0, settle counter=0, pass=0, go to DRIVE. gate_sel changes while not in IDLE have no effect.
- DRIVE: a/b are driven from vec_idx and busy=1. Stay for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: one cycle; a/b held. At the closing edge compare c with the expected value. Any c not identical to the expected value (including x/z in simulation) is a mismatch: set mismatch_vec[vec_idx] and increment err_count.
  - If vec_idx==3, go to DONE.
  - Otherwise increment vec_idx, clear the settle counter and go to DRIVE.
- DONE: one cycle; done=1, busy=1, a=b=0, pass=(err_count==0). Next state is IDLE.
- Latency: start sampled at edge 0; done is high in cycle 4*(SETTLE_CYCLES+1)+1 (9 for default).
- Per vector, a/b are stable for SETTLE_CYCLES+1 cycles.
- start while busy (DRIVE/SAMPLE/DONE): ignored, with no restart and no effect on counters.
- start in IDLE, immediately after DONE: accepted normally, giving back-to-back runs with one IDLE cycle between them.
- err_count never exceeds 4; no wrap.
- err_count, mismatch_vec and pass remain stable in IDLE until the next accepted start.
- Registered outputs only; no combinational path from c to any output.

Test Plan:
1. gate_sel=1, c driven by a correct OR of a/b, default parameter, start pulse -> a/b go 00,01,10,11 with 2 cycles each; done in cycle 9; err_count=0; mismatch_vec=4'b0000; pass=1.
2. gate_sel=1, c driven by an AND of a/b (wrong gate) -> mismatch_vec=4'b0110, err_count=2, pass=0 after done.
3. gate_sel=4 (XOR), c forced to x during vector 2 and correct otherwise -> mismatch_vec=4'b0100, err_count=1, pass=0.
4. Run started; rst=1 for one cycle during the vector-1 SAMPLE -> next cycle all outputs at reset values, state IDLE; a new start then completes normally with pass=1 (correct gate).
5. start re-asserted during DRIVE and SAMPLE, and gate_sel toggled mid-run -> run unaffected, completes on the original schedule with the originally latched gate_sel.
6. SETTLE_CYCLES=3, gate_sel=7, c=~a -> each vector held 4 cycles; done in cycle 17; pass=1; then an immediate second start in IDLE produces a second done pulse 17 cycles later.
